uart_frame_sequencer: RTL

Consumes the byte stream from the UART receiver (8-bit data, toggle-per-byte strobe, bad flag) and frames it into write commands for the game engine's object/sprite register space. Payload bytes are buffered until the frame checksum is verified. Only then is the buffered payload replayed as a write burst over a valid/ready port. Malformed, corrupted or stalled frames are discarded and reported.

---
 rtl/uart_frame_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_sequencer.sv
// Frames a toggle-strobed UART byte stream into checksum-verified write bursts.
// Payload is buffered until the checksum matches, then replayed over valid/ready.
module uart_frame_sequencer #(
    parameter int          ADDR_W      = 8,
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int          TIMEOUT_CYC = 2000000
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [7:0]        rx_data,
    input  logic              rx_toggle,
    input  logic              rx_bad,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              drop
);

    localparam int          BUF_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int          TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0]  ERR_CSUM = 2'd1;
    localparam logic [1:0]  ERR_LEN  = 2'd2;
    localparam logic [1:0]  ERR_RX   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;
    logic              toggle_q;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              ok_d, err_d, drop_d;
    logic [1:0]        code_d;
    logic              buf_we;
    logic              byte_ev;
    logic [7:0]        buffer [MAX_LEN];

    assign byte_ev = rx_toggle ^ toggle_q;

    // Gated so every write-port output reads 0 outside a burst, including
    // immediately on an asynchronous reset.
    assign wr_valid = (state_q == S_WRITE);
    assign wr_addr  = wr_valid ? (base_q + ADDR_W'(idx_q)) : '0;
    assign wr_data  = wr_valid ? buffer[idx_q[BUF_W-1:0]] : '0;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a variable unassigned (no inferred latches).
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        tmo_d   = '0;
        buf_we  = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = err_code;
        drop_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (byte_ev && !rx_bad && rx_data == HEADER) state_d = S_ADDR;
            end

            S_WRITE: begin
                drop_d = byte_ev;
                if (wr_ready) begin
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        ok_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end

            // Parsing states: a bad byte or an inter-byte timeout aborts the frame.
            default: begin
                if (byte_ev && rx_bad) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_RX;
                end else if (byte_ev) begin
                    case (state_q)
                        S_ADDR: begin
                            base_d  = ADDR_W'(rx_data);
                            csum_d  = rx_data;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                state_d = S_IDLE;
                                err_d   = 1'b1;
                                code_d  = ERR_LEN;
                            end else begin
                                len_d   = rx_data;
                                csum_d  = csum_q + rx_data;
                                idx_d   = '0;
                                state_d = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            buf_we = 1'b1;
                            csum_d = csum_q + rx_data;
                            idx_d  = idx_q + 8'd1;
                            if (idx_q == len_q - 8'd1) state_d = S_CSUM;
                        end
                        S_CSUM: begin
                            idx_d = '0;
                            if (rx_data == csum_q) begin
                                state_d = S_WRITE;
                            end else begin
                                state_d = S_IDLE;
                                err_d   = 1'b1;
                                code_d  = ERR_CSUM;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_RX;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            toggle_q  <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= '0;
            drop      <= 1'b0;
        end else begin
            state_q   <= state_d;
            toggle_q  <= rx_toggle;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            err_code  <= code_d;
            drop      <= drop_d;
        end
    end

    // NOTE: the payload buffer has no reset; it is always written before it
    // is read, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge CLOCK) begin
        if (buf_we) buffer[idx_q[BUF_W-1:0]] <= rx_data;
    end

endmodule
